axi_10g_ethernet_0_arp_receive: RTL and testbench

ARP receive parser on the 10G MAC RX AXI-Stream path (64-bit, no backpressure). It inspects each incoming frame and recognises ARP requests targeting the board's IP, then pulses `tx_arp_en` with the requester's MAC/IP to trigger the ARP reply generator. ARP replies addressed to the board are flagged separately for a future ARP cache. All other frames are ignored, and saturating counters report accepted and dropped ARP traffic.

---
 rtl/axi_10g_ethernet_0_pkg.sv | 37 +++
 rtl/axi_10g_ethernet_0_sat_counter.sv | 23 ++
 rtl/axi_10g_ethernet_0_arp_receive.sv | 152 +++++++++++++++
 tb/tb_axi_10g_ethernet_0_arp_receive.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_10g_ethernet_0_pkg.sv
// Shared ARP/Ethernet constants and byte-order helpers for the 10G ARP
// receive parser and reply generator.
package axi_10g_ethernet_0_pkg;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY = 16'd2;

  localparam logic [2:0] BEAT_DA    = 3'd0;
  localparam logic [2:0] BEAT_ETYPE = 3'd1;
  localparam logic [2:0] BEAT_OPER  = 3'd2;
  localparam logic [2:0] BEAT_SPA   = 3'd3;
  localparam logic [2:0] BEAT_THA   = 3'd4;
  localparam logic [2:0] BEAT_TPA   = 3'd5;

  typedef enum logic [1:0] {
    ST_PARSE,
    ST_WAIT_LAST,
    ST_DISCARD
  } arpRxState_t;

  // Network-order value (first wire byte in the MSBs) to AXIS lane order.
  function automatic logic [47:0] toLanes48(input logic [47:0] netOrder);
    logic [47:0] lanes;
    for (int i = 0; i < 6; i++) lanes[8*i +: 8] = netOrder[47-8*i -: 8];
    return lanes;
  endfunction

  function automatic logic [15:0] fromLanes16(input logic [15:0] lanes);
    return {lanes[7:0], lanes[15:8]};
  endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_sat_counter.sv
// Saturating up-counter with synchronous clear.
module axi_10g_ethernet_0_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge aclk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/axi_10g_ethernet_0_arp_receive.sv
// ARP receive parser on the 64-bit 10G RX stream: detects requests/replies
// for this board and reports the sender's MAC/IP one cycle after tlast.
module axi_10g_ethernet_0_arp_receive
  import axi_10g_ethernet_0_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h02_00_c0_a8_0a_0a,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd2, 8'd20}
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [63:0] rx_axis_tdata,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  output logic        tx_arp_en,
  output logic        arp_reply_rx,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic [15:0] arp_req_cnt,
  output logic [15:0] arp_drop_cnt
);

  localparam logic [47:0] MAC_LANES = toLanes48(BOARD_MAC);

  arpRxState_t r_state;
  logic [2:0]  r_beat;
  logic        r_hdrOk, r_isArp;
  logic [15:0] r_oper, r_shaLo;
  logic [31:0] r_shaHi, r_spa;
  logic        r_txArpEn, r_replyRx;
  logic [47:0] r_srcMac;
  logic [31:0] r_srcIp;

  logic w_fullKeep, w_ethOk, w_beatOk, w_inParse, w_isArpNow, w_hdrOkNow;
  logic w_reached5, w_frameEnd, w_accept, w_req, w_reply, w_drop;

  // Decision terms include the current beat so a tlast beat judges itself.
  always_comb begin
    w_fullKeep = (rx_axis_tkeep == 8'hFF);
    w_ethOk    = (fromLanes16(rx_axis_tdata[47:32]) == ETH_TYPE_ARP);
    w_beatOk   = 1'b0;
    case (r_beat)
      BEAT_DA:    w_beatOk = w_fullKeep && ((rx_axis_tdata[47:0] == 48'hFFFF_FFFF_FFFF) ||
                                            (rx_axis_tdata[47:0] == MAC_LANES));
      BEAT_ETYPE: w_beatOk = w_fullKeep && (fromLanes16(rx_axis_tdata[63:48]) == ARP_HTYPE_ETH);
      BEAT_OPER:  w_beatOk = w_fullKeep && (fromLanes16(rx_axis_tdata[15:0]) == ARP_PTYPE_IPV4) &&
                             (rx_axis_tdata[23:16] == ARP_HLEN_ETH) &&
                             (rx_axis_tdata[31:24] == ARP_PLEN_IPV4);
      BEAT_SPA:   w_beatOk = w_fullKeep;
      BEAT_THA:   w_beatOk = w_fullKeep && (rx_axis_tdata[55:48] == BOARD_IP[31:24]) &&
                             (rx_axis_tdata[63:56] == BOARD_IP[23:16]) &&
                             ((r_oper != ARP_OPER_REPLY) || (rx_axis_tdata[47:0] == MAC_LANES));
      BEAT_TPA:   w_beatOk = (rx_axis_tkeep[1:0] == 2'b11) &&
                             (rx_axis_tdata[7:0] == BOARD_IP[15:8]) &&
                             (rx_axis_tdata[15:8] == BOARD_IP[7:0]);
      default:    w_beatOk = 1'b0;
    endcase

    w_inParse  = (r_state == ST_PARSE);
    w_isArpNow = r_isArp;
    w_hdrOkNow = r_hdrOk;
    if (w_inParse) begin
      if (r_beat == BEAT_DA)         w_isArpNow = 1'b0;
      else if (r_beat == BEAT_ETYPE) w_isArpNow = w_ethOk;
      w_hdrOkNow = ((r_beat == BEAT_DA) ? 1'b1 : r_hdrOk) & w_beatOk;
    end

    w_reached5 = (r_state == ST_WAIT_LAST) || (w_inParse && (r_beat == BEAT_TPA));
    w_frameEnd = rx_axis_tvalid && rx_axis_tlast && (r_state != ST_DISCARD);
    w_accept   = w_frameEnd && w_isArpNow && w_hdrOkNow && w_reached5 && rx_axis_tuser;
    w_req      = w_accept && (r_oper == ARP_OPER_REQ);
    w_reply    = w_accept && (r_oper == ARP_OPER_REPLY);
    w_drop     = w_frameEnd && w_isArpNow && !w_req && !w_reply;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= ST_PARSE;
      r_beat    <= BEAT_DA;
      r_hdrOk   <= 1'b0;
      r_isArp   <= 1'b0;
      r_oper    <= '0;
      r_shaLo   <= '0;
      r_shaHi   <= '0;
      r_spa     <= '0;
      r_txArpEn <= 1'b0;
      r_replyRx <= 1'b0;
      r_srcMac  <= '0;
      r_srcIp   <= '0;
    end else begin
      r_txArpEn <= w_req;
      r_replyRx <= w_reply;
      if (w_req || w_reply) begin
        r_srcMac <= {r_shaHi, r_shaLo};
        r_srcIp  <= r_spa;
      end
      if (rx_axis_tvalid) begin
        if (w_inParse) begin
          r_hdrOk <= w_hdrOkNow;
          r_isArp <= w_isArpNow;
        end
        case (r_state)
          ST_PARSE: begin
            if (r_beat == BEAT_OPER) begin
              r_oper  <= fromLanes16(rx_axis_tdata[47:32]);
              r_shaLo <= rx_axis_tdata[63:48];
            end
            if (r_beat == BEAT_SPA) begin
              r_shaHi <= rx_axis_tdata[31:0];
              r_spa   <= rx_axis_tdata[63:32];
            end
            if (rx_axis_tlast)                          r_beat  <= BEAT_DA;
            else if ((r_beat == BEAT_ETYPE) && !w_ethOk) r_state <= ST_DISCARD;
            else if (r_beat == BEAT_TPA)                 r_state <= ST_WAIT_LAST;
            else                                         r_beat  <= r_beat + 3'd1;
          end
          ST_WAIT_LAST, ST_DISCARD: begin
            if (rx_axis_tlast) begin
              r_state <= ST_PARSE;
              r_beat  <= BEAT_DA;
            end
          end
          default: begin
            r_state <= ST_PARSE;
            r_beat  <= BEAT_DA;
          end
        endcase
      end
    end
  end

  axi_10g_ethernet_0_sat_counter #(.WIDTH(16)) u_reqCnt (
    .aclk  (aclk),
    .clear (areset),
    .inc   (w_req),
    .count (arp_req_cnt)
  );

  axi_10g_ethernet_0_sat_counter #(.WIDTH(16)) u_dropCnt (
    .aclk  (aclk),
    .clear (areset),
    .inc   (w_drop),
    .count (arp_drop_cnt)
  );

  assign tx_arp_en    = r_txArpEn;
  assign arp_reply_rx = r_replyRx;
  assign arp_src_mac  = r_srcMac;
  assign arp_src_ip   = r_srcIp;

endmodule

// File: tb/tb_axi_10g_ethernet_0_arp_receive.sv
// Directed testbench for the ARP receive parser: requests, replies, drops,
// runts, bubbles, back-to-back frames and reset mid-frame.
module tb_axi_10g_ethernet_0_arp_receive;

  localparam logic [47:0] BOARD_MAC_N = 48'h02_00_c0_a8_0a_0a;
  localparam logic [31:0] BOARD_IP_N  = 32'hc0_a8_02_14;
  localparam logic [47:0] BCAST       = 48'hFFFF_FFFF_FFFF;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] rx_axis_tdata;
  logic [7:0]  rx_axis_tkeep;
  logic        rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser;
  logic        tx_arp_en, arp_reply_rx;
  logic [47:0] arp_src_mac;
  logic [31:0] arp_src_ip;
  logic [15:0] arp_req_cnt, arp_drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int reqPulses = 0;
  int replyPulses = 0;
  int lastReqCyc = -1;
  int tlastCyc = 0;
  logic [7:0] fb [64];

  axi_10g_ethernet_0_arp_receive dut (
    .aclk           (aclk),
    .areset         (areset),
    .rx_axis_tdata  (rx_axis_tdata),
    .rx_axis_tkeep  (rx_axis_tkeep),
    .rx_axis_tvalid (rx_axis_tvalid),
    .rx_axis_tlast  (rx_axis_tlast),
    .rx_axis_tuser  (rx_axis_tuser),
    .tx_arp_en      (tx_arp_en),
    .arp_reply_rx   (arp_reply_rx),
    .arp_src_mac    (arp_src_mac),
    .arp_src_ip     (arp_src_ip),
    .arp_req_cnt    (arp_req_cnt),
    .arp_drop_cnt   (arp_drop_cnt)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc++;

  // Pulse monitor: a pulse wider than one cycle is counted twice.
  always @(negedge aclk) begin
    if (tx_arp_en === 1'b1) begin
      reqPulses++;
      lastReqCyc = cyc;
    end
    if (arp_reply_rx === 1'b1) replyPulses++;
  end

  // Frame bytes are given in network order (first wire byte in MSBs).
  task automatic buildArp(input logic [47:0] da, input logic [15:0] etype,
                          input logic [15:0] oper, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [47:0] tha,
                          input logic [31:0] tpa);
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]      = da[47-8*i -: 8];
      fb[6+i]    = 8'hA0 + 8'(i);
      fb[22+i]   = sha[47-8*i -: 8];
      fb[32+i]   = tha[47-8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      fb[28+i] = spa[31-8*i -: 8];
      fb[38+i] = tpa[31-8*i -: 8];
    end
    fb[12] = etype[15:8]; fb[13] = etype[7:0];
    fb[14] = 8'h00;       fb[15] = 8'h01;
    fb[16] = 8'h08;       fb[17] = 8'h00;
    fb[18] = 8'h06;       fb[19] = 8'h04;
    fb[20] = oper[15:8];  fb[21] = oper[7:0];
  endtask

  task automatic driveBeat(input int k, input logic isLast, input logic user,
                           input logic [7:0] keep);
    @(negedge aclk);
    for (int i = 0; i < 8; i++) rx_axis_tdata[8*i +: 8] = fb[8*k+i];
    rx_axis_tkeep  = keep;
    rx_axis_tvalid = 1'b1;
    rx_axis_tlast  = isLast;
    rx_axis_tuser  = isLast ? user : 1'b0;
    if (isLast) tlastCyc = cyc;
  endtask

  // An 8-beat frame is 60 bytes, so its last beat carries 4 bytes.
  task automatic applyStimulus(input int nBeats, input logic user, input logic [7:0] bubbles);
    for (int k = 0; k < nBeats; k++) begin
      if (bubbles[k]) begin
        @(negedge aclk);
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      driveBeat(k, k == nBeats - 1, user,
                (k == nBeats - 1 && nBeats == 8) ? 8'h0F : 8'hFF);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
      rx_axis_tuser  = 1'b0;
    end
  endtask

  task automatic buildRequest(input logic [31:0] tpa);
    buildArp(BCAST, 16'h0806, 16'd1, 48'h00_11_22_33_44_55, 32'hc0_a8_02_64, 48'h0, tpa);
  endtask

  task automatic test_reset;
    checks++; if (tx_arp_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_txen got %b want 0", tx_arp_en); end
    checks++; if (arp_reply_rx !== 1'b0) begin errors++; $display("[TB] FAIL reset_reply got %b want 0", arp_reply_rx); end
    checks++; if (arp_src_mac !== 48'h0) begin errors++; $display("[TB] FAIL reset_mac got %h want 0", arp_src_mac); end
    checks++; if (arp_src_ip !== 32'h0) begin errors++; $display("[TB] FAIL reset_ip got %h want 0", arp_src_ip); end
    checks++; if (arp_req_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_reqcnt got %0d want 0", arp_req_cnt); end
    checks++; if (arp_drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_dropcnt got %0d want 0", arp_drop_cnt); end
  endtask

  task automatic test_request;
    buildRequest(BOARD_IP_N);
    applyStimulus(8, 1'b1, 8'h00);
    idle(2);
    checks++; if (reqPulses != 1) begin errors++; $display("[TB] FAIL req_pulses got %0d want 1", reqPulses); end
    checks++; if (lastReqCyc != tlastCyc + 1) begin errors++; $display("[TB] FAIL req_latency got cycle %0d want %0d", lastReqCyc, tlastCyc + 1); end
    checks++; if (arp_src_mac !== 48'h5544_3322_1100) begin errors++; $display("[TB] FAIL req_mac got %h want 554433221100", arp_src_mac); end
    checks++; if (arp_src_ip !== 32'h6402_a8c0) begin errors++; $display("[TB] FAIL req_ip got %h want 6402a8c0", arp_src_ip); end
    checks++; if (arp_req_cnt !== 16'd1) begin errors++; $display("[TB] FAIL req_cnt got %0d want 1", arp_req_cnt); end
    checks++; if (replyPulses != 0) begin errors++; $display("[TB] FAIL req_noreply got %0d want 0", replyPulses); end
  endtask

  task automatic test_drop;
    buildRequest(32'hc0_a8_02_15);
    applyStimulus(8, 1'b1, 8'h00);
    idle(2);
    checks++; if (arp_drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_tpa_cnt got %0d want 1", arp_drop_cnt); end
    checks++; if (reqPulses != 1) begin errors++; $display("[TB] FAIL drop_tpa_pulses got %0d want 1", reqPulses); end
    buildRequest(BOARD_IP_N);
    applyStimulus(8, 1'b0, 8'h00);
    idle(2);
    checks++; if (arp_drop_cnt !== 16'd2) begin errors++; $display("[TB] FAIL drop_tuser_cnt got %0d want 2", arp_drop_cnt); end
    checks++; if (reqPulses != 1) begin errors++; $display("[TB] FAIL drop_tuser_pulses got %0d want 1", reqPulses); end
    checks++; if (arp_req_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_reqcnt got %0d want 1", arp_req_cnt); end
    checks++; if (arp_src_mac !== 48'h5544_3322_1100) begin errors++; $display("[TB] FAIL drop_mac_hold got %h want 554433221100", arp_src_mac); end
  endtask

  task automatic test_back_to_back;
    buildArp(BCAST, 16'h0800, 16'd1, 48'h00_11_22_33_44_55, 32'hc0_a8_02_64, 48'h0, BOARD_IP_N);
    applyStimulus(8, 1'b1, 8'b0010_0100);
    buildRequest(BOARD_IP_N);
    applyStimulus(8, 1'b1, 8'b0100_1010);
    idle(2);
    checks++; if (reqPulses != 2) begin errors++; $display("[TB] FAIL b2b_pulses got %0d want 2", reqPulses); end
    checks++; if (arp_req_cnt !== 16'd2) begin errors++; $display("[TB] FAIL b2b_reqcnt got %0d want 2", arp_req_cnt); end
    checks++; if (arp_drop_cnt !== 16'd2) begin errors++; $display("[TB] FAIL b2b_dropcnt got %0d want 2", arp_drop_cnt); end
    checks++; if (lastReqCyc != tlastCyc + 1) begin errors++; $display("[TB] FAIL b2b_latency got cycle %0d want %0d", lastReqCyc, tlastCyc + 1); end
  endtask

  task automatic test_reply;
    buildArp(BOARD_MAC_N, 16'h0806, 16'd2, 48'h10_20_30_40_50_60, 32'hc0_a8_02_32,
             BOARD_MAC_N, BOARD_IP_N);
    applyStimulus(8, 1'b1, 8'h00);
    idle(2);
    checks++; if (replyPulses != 1) begin errors++; $display("[TB] FAIL reply_pulses got %0d want 1", replyPulses); end
    checks++; if (reqPulses != 2) begin errors++; $display("[TB] FAIL reply_noreq got %0d want 2", reqPulses); end
    checks++; if (arp_src_mac !== 48'h6050_4030_2010) begin errors++; $display("[TB] FAIL reply_mac got %h want 605040302010", arp_src_mac); end
    checks++; if (arp_src_ip !== 32'h3202_a8c0) begin errors++; $display("[TB] FAIL reply_ip got %h want 3202a8c0", arp_src_ip); end
    checks++; if (arp_req_cnt !== 16'd2) begin errors++; $display("[TB] FAIL reply_reqcnt got %0d want 2", arp_req_cnt); end
    checks++; if (arp_drop_cnt !== 16'd2) begin errors++; $display("[TB] FAIL reply_dropcnt got %0d want 2", arp_drop_cnt); end
  endtask

  task automatic test_runt;
    buildRequest(BOARD_IP_N);
    applyStimulus(4, 1'b1, 8'h00);
    idle(2);
    checks++; if (arp_drop_cnt !== 16'd3) begin errors++; $display("[TB] FAIL runt_dropcnt got %0d want 3", arp_drop_cnt); end
    checks++; if (reqPulses != 2) begin errors++; $display("[TB] FAIL runt_pulses got %0d want 2", reqPulses); end
    checks++; if (arp_src_mac !== 48'h6050_4030_2010) begin errors++; $display("[TB] FAIL runt_mac_hold got %h want 605040302010", arp_src_mac); end
    applyStimulus(8, 1'b1, 8'h00);
    idle(2);
    checks++; if (reqPulses != 3) begin errors++; $display("[TB] FAIL runt_next_pulses got %0d want 3", reqPulses); end
    checks++; if (arp_req_cnt !== 16'd3) begin errors++; $display("[TB] FAIL runt_next_reqcnt got %0d want 3", arp_req_cnt); end
    checks++; if (arp_src_mac !== 48'h5544_3322_1100) begin errors++; $display("[TB] FAIL runt_next_mac got %h want 554433221100", arp_src_mac); end
  endtask

  task automatic test_reset_mid_frame;
    buildRequest(BOARD_IP_N);
    driveBeat(0, 1'b0, 1'b0, 8'hFF);
    driveBeat(1, 1'b0, 1'b0, 8'hFF);
    driveBeat(2, 1'b0, 1'b0, 8'hFF);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    rx_axis_tvalid = 1'b0;
    idle(3);
    checks++; if (arp_req_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_reqcnt got %0d want 0", arp_req_cnt); end
    checks++; if (arp_drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_dropcnt got %0d want 0", arp_drop_cnt); end
    checks++; if (arp_src_mac !== 48'h0) begin errors++; $display("[TB] FAIL rst_mid_mac got %h want 0", arp_src_mac); end
    checks++; if (reqPulses != 3) begin errors++; $display("[TB] FAIL rst_mid_pulses got %0d want 3", reqPulses); end
    applyStimulus(8, 1'b1, 8'h00);
    idle(2);
    checks++; if (reqPulses != 4) begin errors++; $display("[TB] FAIL rst_fresh_pulses got %0d want 4", reqPulses); end
    checks++; if (arp_req_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rst_fresh_reqcnt got %0d want 1", arp_req_cnt); end
    checks++; if (arp_drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_fresh_dropcnt got %0d want 0", arp_drop_cnt); end
    checks++; if (arp_src_ip !== 32'h6402_a8c0) begin errors++; $display("[TB] FAIL rst_fresh_ip got %h want 6402a8c0", arp_src_ip); end
  endtask

  initial begin
    areset         = 1'b1;
    rx_axis_tdata  = '0;
    rx_axis_tkeep  = '0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    test_reset;
    test_request;
    test_drop;
    test_back_to_back;
    test_reply;
    test_runt;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
